// File: rtl/alu_pkg.sv
// alu_pkg: ALU operation encodings and data width shared by the operand stage and the ALU
package alu_pkg;
   localparam int DATA_W = 32;
   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_OR  = 2'b11
   } aluc_e;
endpackage

// File: rtl/rf32x32.sv
// rf32x32: 32x32 register file, async clear, two read ports plus a debug peek, register 0 hardwired to zero
module rf32x32
   import alu_pkg::*;
(
   input  logic              clk,
   input  logic              clrn,
   input  logic              we,
   input  logic [4:0]        wa,
   input  logic [DATA_W-1:0] wd,
   input  logic [4:0]        ra_a,
   input  logic [4:0]        ra_b,
   input  logic [4:0]        dbg_a,
   output logic [DATA_W-1:0] qa,
   output logic [DATA_W-1:0] qb,
   output logic [DATA_W-1:0] qdbg
);
   logic [DATA_W-1:0] mem [32];

   // write port; register 0 never stored, whole array cleared on reset
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         for (int i = 0; i < 32; i++) mem[i] <= '0;
      end else if (we && wa != '0) begin
         mem[wa] <= wd;
      end
   end

   assign qa   = ra_a  == '0 ? '0 : mem[ra_a];
   assign qb   = ra_b  == '0 ? '0 : mem[ra_b];
   assign qdbg = dbg_a == '0 ? '0 : mem[dbg_a];
endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: operand fetch with writeback bypass, stall hold and retired-op counter
module alu_operand_stage
   import alu_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic              Clk,
   input  logic              Clrn,
   input  logic              In_valid,
   output logic              In_ready,
   input  logic [4:0]        Ra,
   input  logic [4:0]        Rb,
   input  logic [4:0]        Rd,
   input  logic [1:0]        Aluc_in,
   input  logic              Stall,
   output logic [DATA_W-1:0] X,
   output logic [DATA_W-1:0] Y,
   output logic [1:0]        Aluc,
   output logic              Out_valid,
   input  logic [DATA_W-1:0] R,
   input  logic              Z,
   output logic              Zflag,
   output logic [CNT_W-1:0]  Retired,
   input  logic [4:0]        Dbg_addr,
   output logic [DATA_W-1:0] Dbg_data
);
   logic [4:0]        rd_q;
   logic [DATA_W-1:0] rf_a, rf_b, x_nxt, y_nxt;
   logic              accept, retire, byp_a, byp_b;

   assign In_ready = ~Stall;
   assign accept   = In_valid & In_ready;
   assign retire   = Out_valid & ~Stall;

   rf32x32 u_rf (
      .clk   (Clk),
      .clrn  (Clrn),
      .we    (retire),
      .wa    (rd_q),
      .wd    (R),
      .ra_a  (Ra),
      .ra_b  (Rb),
      .dbg_a (Dbg_addr),
      .qa    (rf_a),
      .qb    (rf_b),
      .qdbg  (Dbg_data)
   );

   // forward the result being written this cycle; rd_q != 0 already excludes register 0
   always_comb begin
      byp_a = retire && rd_q != '0 && Ra == rd_q;
      byp_b = retire && rd_q != '0 && Rb == rd_q;
      x_nxt = byp_a ? R : rf_a;
      y_nxt = byp_b ? R : rf_b;
   end

   // operand/control registers; everything freezes while stalled
   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         X         <= '0;
         Y         <= '0;
         Aluc      <= ALU_ADD;
         rd_q      <= '0;
         Out_valid <= 1'b0;
         Zflag     <= 1'b0;
         Retired   <= '0;
      end else if (!Stall) begin
         Out_valid <= accept;
         if (accept) begin
            X    <= x_nxt;
            Y    <= y_nxt;
            Aluc <= Aluc_in;
            rd_q <= Rd;
         end
         if (retire) begin
            Zflag   <= Z;
            Retired <= Retired + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: scoreboard bench for the operand stage with a bench-side ALU model
module tb_alu_operand_stage;
   typedef struct packed {
      logic [31:0] x;
      logic [31:0] y;
      logic [1:0]  op;
   } exp_t;

   logic        Clk = 0, Clrn = 0;
   logic        In_valid = 0, Stall = 0;
   logic [4:0]  Ra = 0, Rb = 0, Rd = 0, Dbg_addr = 0;
   logic [1:0]  Aluc_in = 0;
   logic        In_ready, Out_valid, Zflag, Z;
   logic [31:0] X, Y, R, Dbg_data;
   logic [1:0]  Aluc;
   logic [15:0] Retired;
   logic        ovr_en = 0;
   logic [31:0] ovr_val = 0;

   logic        w_valid = 0;
   logic        w_ready, w_ov, w_zf;
   logic [31:0] w_x, w_y, w_dbg;
   logic [1:0]  w_aluc;
   logic [3:0]  w_ret;

   exp_t sb[$];
   int   pass_cnt = 0, tot_cnt = 0;

   always #5 Clk = ~Clk;

   alu_operand_stage #(.CNT_W(16)) dut (
      .Clk(Clk), .Clrn(Clrn), .In_valid(In_valid), .In_ready(In_ready),
      .Ra(Ra), .Rb(Rb), .Rd(Rd), .Aluc_in(Aluc_in), .Stall(Stall),
      .X(X), .Y(Y), .Aluc(Aluc), .Out_valid(Out_valid), .R(R), .Z(Z),
      .Zflag(Zflag), .Retired(Retired), .Dbg_addr(Dbg_addr), .Dbg_data(Dbg_data)
   );

   alu_operand_stage #(.CNT_W(4)) u_w (
      .Clk(Clk), .Clrn(Clrn), .In_valid(w_valid), .In_ready(w_ready),
      .Ra(5'd0), .Rb(5'd0), .Rd(5'd0), .Aluc_in(2'b00), .Stall(1'b0),
      .X(w_x), .Y(w_y), .Aluc(w_aluc), .Out_valid(w_ov), .R(32'd0), .Z(1'b1),
      .Zflag(w_zf), .Retired(w_ret), .Dbg_addr(5'd0), .Dbg_data(w_dbg)
   );

   // bench ALU: combinational from X/Y/Aluc unless a forced result is injected
   always_comb begin
      case (Aluc)
         2'b00:   R = X + Y;
         2'b01:   R = X - Y;
         2'b10:   R = X & Y;
         default: R = X | Y;
      endcase
      if (ovr_en) R = ovr_val;
      Z = (R == 32'd0);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tot_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
   endtask

   // monitor: compare each retiring operation against the oldest expectation
   always @(negedge Clk) begin
      if (Clrn && Out_valid && !Stall) begin
         if (sb.size() == 0) begin
            tot_cnt++;
            $display("FAIL sb_underflow actual=retire expected=none at %0t", $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("mon_x", X, e.x);
            chk("mon_y", Y, e.y);
            chk("mon_aluc", {30'd0, Aluc}, {30'd0, e.op});
         end
      end
   end

   task automatic drive(input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rd,
                        input logic [1:0] op, input logic [31:0] ex, input logic [31:0] ey);
      In_valid = 1; Ra = ra; Rb = rb; Rd = rd; Aluc_in = op;
      sb.push_back('{x: ex, y: ey, op: op});
      @(posedge Clk); #1;
   endtask

   task automatic preload(input logic [4:0] rd, input logic [31:0] val);
      drive(0, 0, rd, 2'b00, 0, 0);
      In_valid = 0; ovr_en = 1; ovr_val = val;
      @(posedge Clk); #1;
      ovr_en = 0;
   endtask

   task automatic peek(input string nm, input logic [4:0] a, input logic [31:0] exp);
      Dbg_addr = a; #1;
      chk(nm, Dbg_data, exp);
   endtask

   initial begin
      #22 Clrn = 1;
      for (int i = 0; i < 32; i++) peek("rst_rf", i[4:0], 0);
      chk("rst_ov", {31'd0, Out_valid}, 0);
      chk("rst_ret", {16'd0, Retired}, 0);
      chk("rst_ready", {31'd0, In_ready}, 1);
      @(posedge Clk); #1;
      drive(0, 0, 1, 2'b00, 0, 0);
      In_valid = 0; ovr_en = 1; ovr_val = 0;
      drive(0, 0, 0, 2'b00, 0, 0);
      In_valid = 0; ovr_val = 5;
      @(posedge Clk); #1;
      ovr_en = 0;
      peek("r1_zero", 1, 0);
      peek("r0_zero", 0, 0);
      chk("ret_2", {16'd0, Retired}, 2);
      preload(2, 7);
      preload(3, 3);
      peek("r2_pre", 2, 7);
      peek("r3_pre", 3, 3);
      drive(2, 3, 4, 2'b01, 7, 3);
      drive(4, 4, 5, 2'b00, 4, 4);
      In_valid = 0;
      @(posedge Clk); #1;
      peek("r4_sub", 4, 4);
      peek("r5_byp", 5, 8);
      chk("zf_r5", {31'd0, Zflag}, 0);
      chk("ret_6", {16'd0, Retired}, 6);
      preload(6, 9);
      drive(2, 2, 6, 2'b01, 7, 7);
      Stall = 1; In_valid = 1; Ra = 3; Rb = 3; Rd = 9; Aluc_in = 2'b11;
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk);
         chk("stl_ov", {31'd0, Out_valid}, 1);
         chk("stl_x", X, 7);
         chk("stl_y", Y, 7);
         chk("stl_ready", {31'd0, In_ready}, 0);
         chk("stl_ret", {16'd0, Retired}, 7);
         chk("stl_zf", {31'd0, Zflag}, 0);
         peek("stl_r6", 6, 9);
      end
      @(posedge Clk); #1;
      Stall = 0; In_valid = 0;
      @(posedge Clk); #1;
      peek("r6_zero", 6, 0);
      chk("zf_r6", {31'd0, Zflag}, 1);
      chk("ret_8", {16'd0, Retired}, 8);
      chk("idle_ov", {31'd0, Out_valid}, 0);
      drive(2, 3, 7, 2'b00, 7, 3);
      In_valid = 0;
      #2 Clrn = 0;
      #1;
      chk("arst_ov", {31'd0, Out_valid}, 0);
      chk("arst_x", X, 0);
      chk("arst_y", Y, 0);
      chk("arst_ret", {16'd0, Retired}, 0);
      chk("arst_zf", {31'd0, Zflag}, 0);
      peek("arst_r2", 2, 0);
      sb.delete();
      @(posedge Clk); #3;
      Clrn = 1;
      peek("nowb_r7", 7, 0);
      drive(0, 0, 8, 2'b00, 0, 0);
      In_valid = 0; ovr_en = 1; ovr_val = 32'h1234;
      @(posedge Clk); #1;
      ovr_en = 0;
      peek("post_rst_r8", 8, 32'h1234);
      chk("post_rst_ret", {16'd0, Retired}, 1);
      w_valid = 1;
      repeat (16) @(posedge Clk);
      #1 chk("wrap_15", {28'd0, w_ret}, 15);
      @(posedge Clk); #1;
      chk("wrap_0", {28'd0, w_ret}, 0);
      w_valid = 0;
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge Clk);
      chk("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end
endmodule
